program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 184 ++++++++++++++++++
 tb/tb_program_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Loads a program image from a UART byte stream into a RAM. The stream is a
//   4-byte little-endian word count N followed by N little-endian 32-bit words.
//   Word k is written to RAM address BASE_ADDR + 2*k. The RAM is addressed in
//   byte pairs, so every word uses two address steps and bit 0 is always 0.
//
// Ports:
//   clk                - single clock, rising edge
//   rst                - synchronous, active-high reset
//   rx_data[7:0]       - received byte from the UART receiver
//   rx_valid           - one-cycle strobe qualifying rx_data
//   ram_write_address  - RAM write address (held between writes)
//   ram_write_enable   - one-cycle RAM write strobe
//   ram_write_data     - assembled 32-bit word (held between writes)
//   busy               - header partly received, or load in progress
//   load_done          - level, all N words written (or N was 0)
//   overflow_error     - level, N exceeds the RAM space above BASE_ADDR
//   words_loaded       - number of words written since reset
//   dbg_state          - current FSM state, for observation only
//
// Handshake:
//   rx_valid/rx_data form a valid-only stream with no ready. Every byte
//   strobed in HEADER or LOAD is consumed the cycle it is presented. Bytes that
//   arrive in DONE or ERROR, or after the last word of a load has been received,
//   are dropped. A byte presented while rst is high is dropped.
// -----------------------------------------------------------------------------

`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

module program_loader #(
  parameter int ADDR_W    = `RAM_ADDRESS_BITWIDTH,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic              ram_write_enable,
  output logic [31:0]       ram_write_data,
  output logic              busy,
  output logic              load_done,
  output logic              overflow_error,
  output logic [ADDR_W-1:0] words_loaded,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  // Number of words that fit between BASE_ADDR and the top of the RAM. Held
  // in 33 bits so it can be compared with any 32-bit word count.
  localparam logic [32:0] CAP =
    ((33'd1 << ADDR_W) - 33'(BASE_ADDR)) >> 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_q;
  logic [1:0]        cnt_q;      // byte lane of the next byte
  logic [31:0]       asm_q;      // assembly register for the current word
  logic [31:0]       n_q;        // latched word count
  logic              pend_q;     // a complete word waits for its write cycle
  logic [31:0]       hold_q;     // the word waiting to be written
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] words_q;

  logic              last_pend;
  logic              accept;
  logic [1:0]        cnt_d;
  logic [31:0]       word_d;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    // The final word is complete once it is pending; anything that arrives
    // after it belongs to no word and is dropped.
    last_pend = pend_q && ((32'(words_q) + 32'd1) == n_q);
    accept    = rx_valid &&
                ((state_q == ST_HEADER) || ((state_q == ST_LOAD) && !last_pend));
    cnt_d     = cnt_q + 2'd1;
    word_d    = asm_q;
    word_d[{cnt_q, 3'b000} +: 8] = rx_data;
    addr_d    = BASE + (words_q << 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HEADER;
      cnt_q   <= 2'd0;
      asm_q   <= 32'd0;
      n_q     <= 32'd0;
      pend_q  <= 1'b0;
      hold_q  <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      data_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      we_q <= 1'b0;

      if (accept) begin
        cnt_q <= cnt_d;
        asm_q <= word_d;
      end

      case (state_q)
        ST_HEADER: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (cnt_q == 2'd3) begin
              n_q <= word_d;
              if (word_d == 32'd0) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if ({1'b0, word_d} > CAP) begin
                state_q <= ST_ERROR;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
              end else begin
                state_q <= ST_LOAD;
              end
            end
          end
        end

        ST_LOAD: begin
          // Write cycle for the word completed on the previous edge.
          if (pend_q) begin
            we_q    <= 1'b1;
            data_q  <= hold_q;
            addr_q  <= addr_d;
            words_q <= words_q + ADDR_W'(1);
            pend_q  <= 1'b0;
            if (last_pend) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          // The assembled word moves to a separate holding register so
          // byte 0 of the next word can land during the write cycle.
          if (accept && (cnt_q == 2'd3)) begin
            hold_q <= word_d;
            pend_q <= 1'b1;
          end
        end

        ST_DONE, ST_ERROR: begin
          // Terminal until reset.
        end

        default: begin
          state_q <= ST_HEADER;
        end
      endcase
    end
  end

  assign ram_write_address = addr_q;
  assign ram_write_enable  = we_q;
  assign ram_write_data    = data_q;
  assign busy              = busy_q;
  assign load_done         = done_q;
  assign overflow_error    = err_q;
  assign words_loaded      = words_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Two loaders see the same byte stream:
//   a : ADDR_W=4, BASE_ADDR=0  (room for 8 words)
//   b : ADDR_W=5, BASE_ADDR=8  (room for 12 words)
// A stream-level reference model predicts, for every clock edge, the outputs
// of both instances. All outputs are compared every cycle, plus a few
// directed end-of-scenario checks against constants.
// -----------------------------------------------------------------------------

module tb_program_loader;

  localparam int AW_A   = 4;
  localparam int BASE_A = 0;
  localparam int AW_B   = 5;
  localparam int BASE_B = 8;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;

  always #5 clk = ~clk;

  logic [AW_A-1:0] a_addr, a_words;
  logic            a_we, a_busy, a_done, a_err;
  logic [31:0]     a_data;
  logic [1:0]      a_state;
  logic [AW_B-1:0] b_addr, b_words;
  logic            b_we, b_busy, b_done, b_err;
  logic [31:0]     b_data;
  logic [1:0]      b_state;

  program_loader #(.ADDR_W(AW_A), .BASE_ADDR(BASE_A)) u_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_write_address(a_addr), .ram_write_enable(a_we),
    .ram_write_data(a_data), .busy(a_busy), .load_done(a_done),
    .overflow_error(a_err), .words_loaded(a_words), .dbg_state(a_state)
  );

  program_loader #(.ADDR_W(AW_B), .BASE_ADDR(BASE_B)) u_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_write_address(b_addr), .ram_write_enable(b_we),
    .ram_write_data(b_data), .busy(b_busy), .load_done(b_done),
    .overflow_error(b_err), .words_loaded(b_words), .dbg_state(b_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Stream view: count accepted bytes; bytes 0..3 are the header, then every
  // 4th byte completes a word, which appears on the RAM port one edge later.
  longint      m_cap  [2];
  int          m_base [2];
  int          m_cnt  [2];
  longint      m_n    [2];
  logic [7:0]  m_bytes[2][4];
  bit          m_pend [2];
  logic [31:0] m_pdata[2];
  int          m_words[2];
  bit          m_done [2];
  bit          m_err  [2];
  bit          e_we   [2];
  int          e_addr [2];
  logic [31:0] e_data [2];
  logic [31:0] exp_q[$];   // words expected to be written, in order, instance a

  initial begin
    m_cap[0]  = ((64'd1 << AW_A) - BASE_A) / 2;
    m_cap[1]  = ((64'd1 << AW_B) - BASE_B) / 2;
    m_base[0] = BASE_A;
    m_base[1] = BASE_B;
  end

  task automatic model_step();
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = 0;  m_n[i] = 0;  m_pend[i] = 0;  m_words[i] = 0;
        m_done[i] = 0; m_err[i] = 0;
        e_we[i] = 0;   e_addr[i] = m_base[i];  e_data[i] = 32'd0;
      end else begin
        e_we[i] = 0;
        if (m_pend[i]) begin
          e_we[i]   = 1;
          e_addr[i] = m_base[i] + 2 * m_words[i];
          e_data[i] = m_pdata[i];
          m_words[i]++;
          m_pend[i] = 0;
          if (m_words[i] == m_n[i]) m_done[i] = 1;
        end
        if (rx_valid && !m_done[i] && !m_err[i] &&
            !(m_cnt[i] >= 4 && (m_cnt[i] - 4) / 4 == m_n[i])) begin
          m_bytes[i][m_cnt[i] % 4] = rx_data;
          m_cnt[i]++;
          if (m_cnt[i] % 4 == 0) begin
            w = {m_bytes[i][3], m_bytes[i][2], m_bytes[i][1], m_bytes[i][0]};
            if (m_cnt[i] == 4) begin
              m_n[i] = w;
              if (w == 32'd0) m_done[i] = 1;
              else if (w > m_cap[i]) m_err[i] = 1;
            end else begin
              m_pend[i]  = 1;
              m_pdata[i] = w;
            end
          end
        end
      end
    end
  endtask

  task automatic chk_dut(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic bsy,
                         input logic dn, input logic er, input logic [31:0] wl);
    string p;
    p = (i == 0) ? "a" : "b";
    chk({p, ".we"},    32'(we),  32'(e_we[i]));
    chk({p, ".addr"},  addr,     32'(e_addr[i]));
    chk({p, ".data"},  data,     e_data[i]);
    chk({p, ".busy"},  32'(bsy), 32'(m_cnt[i] > 0 && !m_done[i] && !m_err[i]));
    chk({p, ".done"},  32'(dn),  32'(m_done[i]));
    chk({p, ".err"},   32'(er),  32'(m_err[i]));
    chk({p, ".words"}, wl,       32'(m_words[i]));
  endtask

  // One clock: model the edge with the inputs that were applied, then check.
  logic [31:0] got_q[$];
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_dut(0, a_we, 32'(a_addr), a_data, a_busy, a_done, a_err, 32'(a_words));
    chk_dut(1, b_we, 32'(b_addr), b_data, b_busy, b_done, b_err, 32'(b_words));
    if (a_we) got_q.push_back(a_data);
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], $urandom_range(0, max_gap));
  endtask

  // Bytes strobed during reset must be dropped.
  task automatic do_reset();
    rst = 1'b1;  rx_valid = 1'b1;  rx_data = 8'($urandom);
    tick();
    rx_valid = 1'($urandom);  rx_data = 8'($urandom);
    tick();
    rst = 1'b0;  rx_valid = 1'b0;
    got_q.delete();
  endtask

  // Full stream of n random words; the words sent go to exp_q.
  task automatic send_stream(input logic [31:0] n, input int max_gap);
    logic [31:0] w;
    exp_q.delete();
    send_word(n, max_gap);
    for (int k = 0; k < int'(n); k++) begin
      w = $urandom;
      exp_q.push_back(w);
      send_word(w, max_gap);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] run0[$];
  logic [31:0] n_r;

  initial begin
    do_reset();

    // Two words back-to-back from the worked example.
    send_word(32'd2, 0);
    send_word(32'h12345678, 0);
    send_word(32'hDEADBEEF, 0);
    idle(3);
    chk("ex.a_data",  a_data,        32'hDEADBEEF);
    chk("ex.a_addr",  32'(a_addr),   32'd2);
    chk("ex.a_words", 32'(a_words),  32'd2);
    chk("ex.a_done",  32'(a_done),   32'd1);
    chk("ex.a_first", got_q.size() > 0 ? got_q[0] : 32'd0, 32'h12345678);
    chk("ex.b_addr",  32'(b_addr),   32'd10);

    // Zero-length image, extra bytes ignored.
    do_reset();
    send_word(32'd0, 0);
    for (int k = 0; k < 6; k++) send_byte(8'($urandom), $urandom_range(0, 2));
    idle(2);
    chk("zero.done",  32'(a_done),  32'd1);
    chk("zero.words", 32'(a_words), 32'd0);

    // One word above capacity of a; b still has room.
    do_reset();
    send_stream(32'd9, 0);
    send_word(32'($urandom), 1);
    idle(3);
    chk("ovf.a_err",   32'(a_err),   32'd1);
    chk("ovf.a_words", 32'(a_words), 32'd0);
    chk("ovf.b_words", 32'(b_words), 32'd9);

    // Exactly full for a: last address 14.
    do_reset();
    send_stream(32'd8, 0);
    idle(3);
    chk("full.a_addr",  32'(a_addr),  32'd14);
    chk("full.a_words", 32'(a_words), 32'd8);
    chk("full.b_addr",  32'(b_addr),  32'd22);

    // Same image gap-free then with random idle gaps must write the same words.
    for (int it = 0; it < 4; it++) begin
      n_r = $urandom_range(1, 8);
      do_reset();
      send_stream(n_r, 0);
      idle(3);
      run0 = got_q;
      do_reset();
      send_word(n_r, 5);
      for (int k = 0; k < run0.size(); k++) send_word(run0[k], 5);
      idle(3);
      chk("gap.count", 32'(got_q.size()), 32'(run0.size()));
      chk("gap.words", 32'(a_words), n_r);
      for (int k = 0; k < run0.size() && k < got_q.size(); k++)
        chk("gap.data", got_q[k], run0[k]);
    end

    // Reset the cycle after byte 3 of word 1: that write must never appear.
    do_reset();
    send_word(32'd3, 0);
    send_word(32'($urandom), 0);
    send_word(32'($urandom), 0);
    do_reset();
    chk("abort.words", 32'(a_words), 32'd0);
    send_stream(32'd2, 1);
    idle(3);
    chk("abort.reload_words", 32'(a_words), 32'd2);
    chk("abort.reload_addr",  32'(a_addr),  32'd2);
    chk("abort.reload_data",  a_data, exp_q.size() > 1 ? exp_q[1] : 32'd0);

    // Single word at a non-zero base.
    do_reset();
    send_word(32'd1, 0);
    send_word(32'h04030201, 0);
    idle(2);
    chk("base.b_data", b_data,       32'h04030201);
    chk("base.b_addr", 32'(b_addr),  32'd8);
    chk("base.b_done", 32'(b_done),  32'd1);

    // Random headers, some far beyond capacity, with a reset mid-header.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      send_byte(8'($urandom), 0);
      send_byte(8'($urandom), 1);
      do_reset();
      n_r = (it % 2 == 0) ? $urandom : $urandom_range(1, 12);
      send_word(n_r, 2);
      for (int k = 0; k < 14 * 4; k++) send_byte(8'($urandom), $urandom_range(0, 1));
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
